// File: rtl/serial_borrow_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first, with
// valid/ready handshakes on both sides. Define SUB_OVF_EN to add the signed overflow output ovf.
module serial_borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic fs_diff(input logic x, input logic y, input logic br);
    return x ^ y ^ br;
  endfunction

  function automatic logic fs_borrow(input logic x, input logic y, input logic br);
    return (~x & y) | (~x & br) | (y & br);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             bit_d, bit_br;

`ifdef SUB_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  // Single full-subtractor cell fed by the operand shift-register LSBs.
  assign bit_d  = fs_diff(a_sh_q[0], b_sh_q[0], br_q);
  assign bit_br = fs_borrow(a_sh_q[0], b_sh_q[0], br_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    br_d        = br_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
`ifdef SUB_OVF_EN
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          diff_d  = '0;
          state_d = RUN;
`ifdef SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        // Result bits enter at the MSB so the first bit ends up in diff[0].
        diff_d = {bit_d, diff_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = bit_br;
        if (cnt_q == LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          bout_d      = bit_br;
`ifdef SUB_OVF_EN
          ovf_d       = (a_msb_q ^ b_msb_q) & (a_msb_q ^ bit_d);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      br_q        <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      br_q        <= br_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
`ifdef SUB_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // Operand storage is only meaningful after an accept, so it needs no reset.
  always_ff @(posedge clk) begin
    a_sh_q  <= a_sh_d;
    b_sh_q  <= b_sh_d;
`ifdef SUB_OVF_EN
    a_msb_q <= a_msb_d;
    b_msb_q <= b_msb_d;
`endif
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Directed bench for serial_borrow_subtractor (WIDTH=4): vector table plus
// stall, ignored-input and mid-run reset sequences.
module tb_serial_borrow_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    a = v.a;
    b = v.b;
    bin = v.bin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({nm, "_busy"}, 32'(in_ready), 32'd0);
    for (int k = 1; k <= W; k++) begin
      chk({nm, "_early_valid"}, 32'(out_valid), 32'd0);
      tick();
    end
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_diff"}, 32'(diff), 32'(v.d));
    chk({nm, "_bout"}, 32'(bout), 32'(v.bo));
`ifdef SUB_OVF_EN
    chk({nm, "_ovf"}, 32'(ovf), 32'(v.ov));
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_drop_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_ready_again"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    //            a      b      bin   diff   bout  ovf
    vecs[0]  = '{4'd9,  4'd3,  1'b0, 4'h6, 1'b0, 1'b1};
    vecs[1]  = '{4'd3,  4'd9,  1'b0, 4'hA, 1'b1, 1'b1};
    vecs[2]  = '{4'd0,  4'd0,  1'b1, 4'hF, 1'b1, 1'b0};
    vecs[3]  = '{4'd5,  4'd2,  1'b0, 4'h3, 1'b0, 1'b0};
    vecs[4]  = '{4'd15, 4'd15, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[5]  = '{4'd8,  4'd1,  1'b0, 4'h7, 1'b0, 1'b1};
    vecs[6]  = '{4'd7,  4'd8,  1'b0, 4'hF, 1'b1, 1'b1};
    vecs[7]  = '{4'd15, 4'd0,  1'b0, 4'hF, 1'b0, 1'b0};
    vecs[8]  = '{4'd4,  4'd4,  1'b0, 4'h0, 1'b0, 1'b0};
    vecs[9]  = '{4'd0,  4'd15, 1'b0, 4'h1, 1'b1, 1'b0};
    vecs[10] = '{4'd10, 4'd5,  1'b1, 4'h4, 1'b0, 1'b1};

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
`ifdef SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Result stalled by consumer for 5 cycles
    a = 4'd9; b = 4'd3; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < W; k++) tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_diff", 32'(diff), 32'h6);
      chk("stall_bout", 32'(bout), 32'd0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_release_valid", 32'(out_valid), 32'd0);
    chk("stall_release_ready", 32'(in_ready), 32'd1);

    // in_valid held with changing operands after accept: 12 - 5 = 7
    a = 4'd12; b = 4'd5; bin = 1'b0; in_valid = 1'b1;
    tick();
    for (int k = 0; k < W + 3; k++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      bin = 1'($urandom);
      tick();
    end
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_diff", 32'(diff), 32'h7);
    chk("hold_bout", 32'(bout), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_release_ready", 32'(in_ready), 32'd1);

    // Reset after two bits of 6 - 1
    a = 4'd6; b = 4'd1; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_in_ready_low", 32'(in_ready), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < W + 2; k++) begin
      chk("abort_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    run_op('{4'd5, 4'd2, 1'b0, 4'h3, 1'b0, 1'b0}, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_borrow_subtractor.md
# serial_borrow_subtractor

Bit-serial subtractor: computes diff = a − b − bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the inverse arithmetic counterpart of the team's ripple-carry adder. Operands enter through a valid/ready handshake and the result leaves through a second valid/ready handshake, so the block sits between a register/operand source and a result consumer in the lab datapath.

## Interface
- WIDTH, 4, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operand set a/b/bin is valid
- in_ready  output  1  block can accept operands (high only in IDLE, low while rst_n low)
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  diff/bout valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a − b − bin mod 2^WIDTH
- bout  output  1  borrow-out (1 when a < b + bin, unsigned)
- ovf  output  1  signed overflow (present only with SUB_OVF_EN)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid && in_ready: latch a, b into shift registers, load borrow FF with bin, bit counter=0, clear diff register, → RUN.
- RUN: each cycle, with x=a_sh[0], y=b_sh[0], br=borrow FF:
  - d = x ^ y ^ br
  - br_next = (~x & y) | (~x & br) | (y & br)
  - d shifted into diff register from MSB side (after WIDTH shifts diff[0] = first bit); a_sh, b_sh shift right; borrow FF ← br_next; counter++.
  - After the cycle with counter == WIDTH−1 → DONE; bout ← final br_next.
- DONE: out_valid=1; diff, bout, ovf held stable. On out_ready → IDLE.
- in_valid outside IDLE ignored; operand inputs only sampled at the accept edge.
- All arithmetic modulo 2^WIDTH; counter width ceil(log2(WIDTH)), no wrap beyond WIDTH−1.

## Timing
- Reset values (rst_n low at edge): state IDLE, out_valid 0, diff 0, bout 0, ovf 0, counter 0, borrow FF 0. in_ready is 0 while rst_n is low, 1 in the first cycle after release.
- Reset has priority over every handshake; rst_n low during RUN or DONE aborts the operation, no out_valid issued, pending result discarded.
- Latency: operands accepted at edge E0; out_valid rises after edge E_WIDTH (WIDTH cycles).
- DONE→IDLE on the edge where out_valid && out_ready; in_ready rises next cycle. No same-cycle result-accept and operand-accept; throughput one operation per WIDTH+2 cycles minimum.
- out_ready held low: block stays in DONE indefinitely, outputs unchanged.
- out_valid, diff, bout, ovf are registered; in_ready is a decode of state gated with rst_n.

## Configuration
- SUB_OVF_EN defined: ovf port present; registered on the RUN→DONE edge as (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]) using latched a[MSB], b[MSB] (sign bits, bin treated as part of subtrahend); cleared on reset and held through DONE.
- SUB_OVF_EN undefined: no ovf port, no sign-bit storage; all other behaviour identical.

## Test plan
- WIDTH=4, a=9, b=3, bin=0 accepted → out_valid exactly 4 cycles later, diff=6, bout=0.
- a=3, b=9, bin=0 → diff=0xA, bout=1; a=0, b=0, bin=1 → diff=0xF, bout=1.
- Result presented with out_ready low for 5 cycles → out_valid, diff, bout stable all 5 cycles; in_ready 0; out_ready high → IDLE, in_ready 1 next cycle.
- in_valid held high with changing a/b during RUN → ignored; result matches operands latched at accept edge.
- rst_n low for one cycle mid-RUN (after 2 bits) → no out_valid, diff=0, bout=0, in_ready 1 after release; next operation 5−2 → diff=3.
- SUB_OVF_EN: a=7, b=8 (−8), bin=0 → diff=0xF, bout=1, ovf=1; a=5, b=2 → diff=3, ovf=0.
